// File: rtl/program_sequencer.sv
// Program-memory address sequencer for the 4-bit microprocessor: fall-through,
// jumps, conditional jumps, a hardware call/return stack, stall and sticky stack error.
module program_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             sync_reset_n,
  input  logic                             hold,
  input  logic                             jmp,
  input  logic                             jmp_nz,
  input  logic                             call,
  input  logic                             ret,
  input  logic [ADDR_W-1:0]                jmp_addr,
  input  logic                             r_eq_0,
  output logic [ADDR_W-1:0]                pm_addr,
  output logic [ADDR_W-1:0]                pc,
  output logic [ADDR_W-1:0]                from_PS,
  output logic [$clog2(STACK_DEPTH):0]     sp,
  output logic                             stack_err
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] pc_inc;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;
  logic              do_push;
  logic              do_pop;
  logic              err_set;

  assign pc_inc   = pc + ADDR_W'(1);
  // Depth is a power of two, so truncating sp-1 always lands on the top entry.
  assign top_idx  = IDX_W'(sp - SP_W'(1));
  assign push_idx = sp[IDX_W-1:0];
  assign from_PS  = pc;

  always_comb begin
    pm_addr = pc_inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    err_set = 1'b0;
    if (!sync_reset_n) begin
      pm_addr = '0;
    end else if (hold) begin
      pm_addr = pc;
    end else if (ret) begin
      if (sp != '0) begin
        pm_addr = stack_q[top_idx];
        do_pop  = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end else if (call) begin
      pm_addr = jmp_addr;
      if (sp < SP_FULL) begin
        do_push = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end else if (jmp) begin
      pm_addr = jmp_addr;
    end else if (jmp_nz && !r_eq_0) begin
      pm_addr = jmp_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      pc        <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      pc <= pm_addr;
      if (do_push) begin
        sp <= sp + SP_W'(1);
      end else if (do_pop) begin
        sp <= sp - SP_W'(1);
      end
      if (err_set) begin
        stack_err <= 1'b1;
      end
    end
  end

  // Stack contents need no reset; do_push is never set while reset is asserted.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with hand-computed expectations.
module tb_program_sequencer;

  logic       clk;
  logic       sync_reset_n;
  logic       hold;
  logic       jmp;
  logic       jmp_nz;
  logic       call;
  logic       ret;
  logic [7:0] jmp_addr;
  logic       r_eq_0;
  logic [7:0] pm_addr;
  logic [7:0] pc;
  logic [7:0] from_PS;
  logic [2:0] sp;
  logic       stack_err;

  int n_tests = 0;
  int n_fail  = 0;

  program_sequencer #(
    .ADDR_W      (8),
    .STACK_DEPTH (4)
  ) dut (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .hold         (hold),
    .jmp          (jmp),
    .jmp_nz       (jmp_nz),
    .call         (call),
    .ret          (ret),
    .jmp_addr     (jmp_addr),
    .r_eq_0       (r_eq_0),
    .pm_addr      (pm_addr),
    .pc           (pc),
    .from_PS      (from_PS),
    .sp           (sp),
    .stack_err    (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hold   = 1'b0;
    jmp    = 1'b0;
    jmp_nz = 1'b0;
    call   = 1'b0;
    ret    = 1'b0;
  endtask

  task automatic jump_to(input logic [7:0] a);
    idle();
    jmp      = 1'b1;
    jmp_addr = a;
    tick();
    idle();
  endtask

  initial begin
    idle();
    sync_reset_n = 1'b0;
    jmp_addr     = 8'h00;
    r_eq_0       = 1'b0;
    #1;
    chk("pm_addr_in_reset", 32'(pm_addr), 32'h00);
    tick();
    tick();
    chk("reset_pc", 32'(pc), 32'h00);
    chk("reset_sp", 32'(sp), 32'd0);
    chk("reset_err", 32'(stack_err), 32'd0);
    chk("reset_pm_addr", 32'(pm_addr), 32'h00);

    // Free run
    sync_reset_n = 1'b1;
    #1;
    chk("free_pm_addr", 32'(pm_addr), 32'h01);
    tick();
    chk("free_pc1", 32'(pc), 32'h01);
    tick();
    chk("free_pc2", 32'(pc), 32'h02);
    tick();
    chk("free_pc3", 32'(pc), 32'h03);

    // Wrap at 0xFF
    jump_to(8'hFF);
    chk("wrap_pre", 32'(pc), 32'hFF);
    #1;
    chk("wrap_pm_addr", 32'(pm_addr), 32'h00);
    tick();
    chk("wrap_pc", 32'(pc), 32'h00);

    // Jumps
    jump_to(8'h05);
    chk("jmp_setup", 32'(pc), 32'h05);
    jmp      = 1'b1;
    jmp_addr = 8'h40;
    #1;
    chk("jmp_pm_addr", 32'(pm_addr), 32'h40);
    tick();
    chk("jmp_pc", 32'(pc), 32'h40);
    chk("from_ps", 32'(from_PS), 32'h40);
    idle();
    jmp_nz   = 1'b1;
    r_eq_0   = 1'b1;
    jmp_addr = 8'h10;
    tick();
    chk("jnz_not_taken", 32'(pc), 32'h41);
    r_eq_0 = 1'b0;
    #1;
    chk("jnz_pm_addr", 32'(pm_addr), 32'h10);
    tick();
    chk("jnz_taken", 32'(pc), 32'h10);

    // Call / return nesting
    jump_to(8'h03);
    call     = 1'b1;
    jmp_addr = 8'h20;
    tick();
    chk("call1_pc", 32'(pc), 32'h20);
    chk("call1_sp", 32'(sp), 32'd1);
    idle();
    tick();
    chk("seq_pc", 32'(pc), 32'h21);
    call     = 1'b1;
    jmp_addr = 8'h30;
    tick();
    chk("call2_pc", 32'(pc), 32'h30);
    chk("call2_sp", 32'(sp), 32'd2);
    idle();
    ret = 1'b1;
    #1;
    chk("ret1_pm_addr", 32'(pm_addr), 32'h22);
    tick();
    chk("ret1_pc", 32'(pc), 32'h22);
    chk("ret1_sp", 32'(sp), 32'd1);
    tick();
    chk("ret2_pc", 32'(pc), 32'h04);
    chk("ret2_sp", 32'(sp), 32'd0);
    chk("ret2_err", 32'(stack_err), 32'd0);

    // Overflow: pushes 05, 61, 62, 63; fifth call is not pushed
    idle();
    call = 1'b1;
    for (int i = 0; i < 4; i++) begin
      jmp_addr = 8'h60 + 8'(i);
      tick();
    end
    chk("ovf_sp4", 32'(sp), 32'd4);
    chk("ovf_err_before", 32'(stack_err), 32'd0);
    jmp_addr = 8'h70;
    tick();
    chk("ovf_pc", 32'(pc), 32'h70);
    chk("ovf_sp", 32'(sp), 32'd4);
    chk("ovf_err", 32'(stack_err), 32'd1);
    idle();
    ret = 1'b1;
    #1;
    chk("ovf_top", 32'(pm_addr), 32'h63);
    tick();
    chk("ovf_pop_sp", 32'(sp), 32'd3);

    // Underflow after reset
    idle();
    sync_reset_n = 1'b0;
    tick();
    sync_reset_n = 1'b1;
    jump_to(8'h07);
    ret = 1'b1;
    #1;
    chk("unf_pm_addr", 32'(pm_addr), 32'h08);
    tick();
    chk("unf_pc", 32'(pc), 32'h08);
    chk("unf_sp", 32'(sp), 32'd0);
    chk("unf_err", 32'(stack_err), 32'd1);

    // Hold and priority
    jump_to(8'h09);
    hold     = 1'b1;
    call     = 1'b1;
    jmp_addr = 8'h55;
    #1;
    chk("hold_pm_addr", 32'(pm_addr), 32'h09);
    tick();
    chk("hold_pc", 32'(pc), 32'h09);
    chk("hold_sp", 32'(sp), 32'd0);
    idle();
    tick();
    chk("pri_setup", 32'(pc), 32'h0A);
    call     = 1'b1;
    jmp      = 1'b1;
    jmp_addr = 8'h50;
    tick();
    chk("call_jmp_pc", 32'(pc), 32'h50);
    chk("call_jmp_sp", 32'(sp), 32'd1);
    idle();
    ret      = 1'b1;
    jmp      = 1'b1;
    jmp_addr = 8'h77;
    #1;
    chk("ret_jmp_pm_addr", 32'(pm_addr), 32'h0B);
    tick();
    chk("ret_jmp_pc", 32'(pc), 32'h0B);
    chk("ret_jmp_sp", 32'(sp), 32'd0);

    // Reset mid-operation
    idle();
    call = 1'b1;
    for (int i = 0; i < 3; i++) begin
      jmp_addr = 8'h20 + 8'(i);
      tick();
    end
    chk("mid_sp3", 32'(sp), 32'd3);
    idle();
    ret          = 1'b1;
    sync_reset_n = 1'b0;
    #1;
    chk("mid_pm_addr", 32'(pm_addr), 32'h00);
    tick();
    chk("mid_pc", 32'(pc), 32'h00);
    chk("mid_sp", 32'(sp), 32'd0);
    chk("mid_err", 32'(stack_err), 32'd0);
    idle();
    sync_reset_n = 1'b1;
    tick();
    chk("post_reset_pc", 32'(pc), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Generates the program-memory address for the 4-bit microprocessor each cycle.
- Sits directly upstream of the computational unit: the instruction decoder turns the fetched word into CU controls (reg_en, source_sel, x_sel, y_sel, i_sel, ir_nibble).
- Consumes the CU zero flag r_eq_0 for conditional jumps.
- Adds sequential fall-through, unconditional/conditional jumps, a small hardware call/return stack, a stall input and a sticky stack-error flag.

Parameters:
- ADDR_W, 8, program-memory address width.
- STACK_DEPTH, 4, number of return-address entries (power of 2, >= 2).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- sync_reset_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
- hold  input  1  stall; when 1, the sequencer refetches the current address.
- jmp  input  1  unconditional jump strobe from the decoder.
- jmp_nz  input  1  conditional jump strobe; taken only when r_eq_0 = 0.
- call  input  1  push return address, then jump.
- ret  input  1  pop return address and jump to it.
- jmp_addr  input  ADDR_W  target for jmp, jmp_nz and call (from the instruction word).
- r_eq_0  input  1  zero flag registered by the computational unit.
- pm_addr  output  ADDR_W  combinational next address to program memory.
- pc  output  ADDR_W  registered address of the instruction currently executing.
- from_PS  output  ADDR_W  debug copy of pc.
- sp  output  log2(STACK_DEPTH)+1  stack occupancy, 0..STACK_DEPTH.
- stack_err  output  1  sticky flag: overflow or underflow occurred.

Behaviour:
- Reset:
  - While sync_reset_n = 0, pm_addr = 0 combinationally.
  - At the clock edge: pc <= 0, sp <= 0, stack_err <= 0.
  - Stack entry contents are don't-care.
  - Reset overrides every other input, including mid-call and hold.
- pc update: pc <= pm_addr every edge. Latency from strobe to pc is 1 cycle; pm_addr reflects the strobe in the same cycle.
- pm_addr selection, highest priority first:
  1. reset -> 0.
  2. hold -> pc. No stack change; all strobes ignored.
  3. ret -> top-of-stack, i.e. entry[sp-1].
  4. call -> jmp_addr.
  5. jmp -> jmp_addr.
  6. jmp_nz with r_eq_0 = 0 -> jmp_addr.
  7. Otherwise -> pc + 1.
- Address arithmetic: pc + 1 is modulo 2^ADDR_W, so 0xFF wraps to 0x00. No carry out.
- Multiple strobes in one cycle: the highest priority wins. Lower strobes have no effect, including no stack change.
- call, when sp < STACK_DEPTH: entry[sp] <= pc + 1 (mod 2^ADDR_W), sp <= sp + 1.
- call, when sp = STACK_DEPTH (overflow): jump still taken, no push, sp unchanged, stack_err <= 1.
- ret, when sp > 0: pm_addr = entry[sp-1], sp <= sp - 1.
- ret, when sp = 0 (underflow): pm_addr = pc + 1, sp stays 0, stack_err <= 1.
- stack_err: cleared only by reset.
- jmp_nz: uses r_eq_0 as presented in the same cycle. The CU flag is already registered, so there is no combinational loop.
- hold with call or ret asserted: neither a push nor a pop occurs.
- from_PS = pc at all times.

Test Plan:
- Reset then free-run: hold sync_reset_n = 0 for 2 cycles, release, no strobes -> pm_addr 0 during reset; pc = 0,1,2,3 on successive edges. Preload pc to 0xFF -> next pc = 0x00.
- Jumps: at pc = 0x05, jmp = 1, jmp_addr = 0x40 -> pm_addr = 0x40 same cycle, pc = 0x40 next edge. jmp_nz with r_eq_0 = 1 -> pc = 0x41. jmp_nz with r_eq_0 = 0, jmp_addr = 0x10 -> pc = 0x10.
- Call/return nesting:
  - Call 0x20 from pc 0x03 -> sp = 1, pc = 0x20.
  - Call 0x30 from 0x21 -> sp = 2.
  - ret -> pc = 0x22, sp = 1.
  - ret -> pc = 0x04, sp = 0, stack_err = 0.
- Overflow/underflow:
  - 5 calls with STACK_DEPTH = 4 -> fifth still jumps, sp = 4, stack_err = 1.
  - After reset, ret at pc 0x07 -> pc = 0x08, sp = 0, stack_err = 1.
- Hold and priority:
  - hold = 1 with call = 1 at pc 0x09 -> pc stays 0x09, sp unchanged.
  - call and jmp together (jmp_addr = 0x50) at pc 0x0A -> push 0x0B, pc = 0x50.
  - ret and jmp together -> ret wins.
- Reset mid-operation: sp = 3, assert sync_reset_n = 0 together with ret -> pm_addr = 0; next edge pc = 0, sp = 0, stack_err = 0.
